clock_controller: RTL and testbench

CLOCK_CONTROLLER -- requirements
Module: clock_controller

---
 rtl/clock_controller.sv | 167 ++++++++++++++++
 tb/tb_clock_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_controller.sv
// clock_controller: 24-hour clock with a settable alarm, driving an 8-digit BCD display mux.
//
// Ports:
//   CLK100MHZ  in   system clock, all state changes on the rising edge
//   CPU_RESETN in   asynchronous active-low reset
//   btn_mode   in   single-cycle pulse, advances RUN->SET_HOUR->SET_MIN->SET_AHOUR->SET_AMIN->RUN
//   btn_up     in   single-cycle pulse, increments the field being edited
//   alarm_en   in   level, enables the alarm output
//   bcd        out  eight BCD digits, nibble 4'hF = blank digit
//   dots       out  decimal points, bit i = digit i
//   alarm_led  out  registered alarm indication
module clock_controller #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        alarm_en,
  output logic [31:0] bcd,
  output logic [7:0]  dots,
  output logic        alarm_led
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_SET_HOUR  = 3'd1;
  localparam logic [2:0] ST_SET_MIN   = 3'd2;
  localparam logic [2:0] ST_SET_AHOUR = 3'd3;
  localparam logic [2:0] ST_SET_AMIN  = 3'd4;

  logic [2:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_hour, r_min, r_sec, r_ahour, r_amin;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          r_alarm_led;

  logic [2:0] w_state_next;
  logic       w_inc;
  logic       w_count_en;
  logic       w_tick;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_alarm_view;

  // BCD increment of a two-digit pair, wrapping to 00 after wrap_at.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] wrap_at);
    logic [7:0] r;
    if (v == wrap_at) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    w_state_next = r_state;
    if (btn_mode) begin
      case (r_state)
        ST_RUN:       w_state_next = ST_SET_HOUR;
        ST_SET_HOUR:  w_state_next = ST_SET_MIN;
        ST_SET_MIN:   w_state_next = ST_SET_AHOUR;
        ST_SET_AHOUR: w_state_next = ST_SET_AMIN;
        default:      w_state_next = ST_RUN;
      endcase
    end
  end

  // A mode pulse wins over an increment in the same cycle.
  assign w_inc      = btn_up & ~btn_mode;
  // Prescaler and seconds are frozen while the time itself is being edited.
  assign w_count_en = (w_state_next != ST_SET_HOUR) && (w_state_next != ST_SET_MIN);
  assign w_tick     = w_count_en && (r_presc == PRESC_MAX);
  assign w_sec_wrap = (r_sec == 8'h59);
  assign w_min_wrap = (r_min == 8'h59);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state       <= ST_RUN;
      r_presc       <= '0;
      r_hour        <= 8'h00;
      r_min         <= 8'h00;
      r_sec         <= 8'h00;
      r_ahour       <= 8'h07;
      r_amin        <= 8'h00;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_alarm_led   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (!w_count_en) begin
        r_presc <= '0;
        r_sec   <= 8'h00;
      end else if (w_tick) begin
        r_presc <= '0;
        r_sec   <= bcd_inc(r_sec, 8'h59);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // Ticks never occur in SET_HOUR/SET_MIN, so carries and edits cannot collide.
      if (w_tick && w_sec_wrap) begin
        r_min <= bcd_inc(r_min, 8'h59);
      end else if (w_inc && (r_state == ST_SET_MIN)) begin
        r_min <= bcd_inc(r_min, 8'h59);
      end

      if (w_tick && w_sec_wrap && w_min_wrap) begin
        r_hour <= bcd_inc(r_hour, 8'h23);
      end else if (w_inc && (r_state == ST_SET_HOUR)) begin
        r_hour <= bcd_inc(r_hour, 8'h23);
      end

      if (w_inc && (r_state == ST_SET_AHOUR)) begin
        r_ahour <= bcd_inc(r_ahour, 8'h23);
      end
      if (w_inc && (r_state == ST_SET_AMIN)) begin
        r_amin <= bcd_inc(r_amin, 8'h59);
      end

      // Every mode pulse changes state, so it restarts the blink cycle visible-first.
      if (btn_mode) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BLINK_MAX) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end

      r_alarm_led <= alarm_en && (r_hour == r_ahour) && (r_min == r_amin);
    end
  end

  assign w_alarm_view = (r_state == ST_SET_AHOUR) || (r_state == ST_SET_AMIN);

  always_comb begin
    if (w_alarm_view) begin
      bcd = {8'hFF, r_ahour, r_amin, 8'hFF};
    end else begin
      bcd = {8'hFF, r_hour, r_min, r_sec};
    end
    if (r_blink_phase) begin
      if ((r_state == ST_SET_HOUR) || (r_state == ST_SET_AHOUR)) begin
        bcd[23:16] = 8'hFF;
      end
      if ((r_state == ST_SET_MIN) || (r_state == ST_SET_AMIN)) begin
        bcd[15:8] = 8'hFF;
      end
    end
    dots = w_alarm_view ? 8'b1001_0100 : 8'b0001_0100;
  end

  assign alarm_led = r_alarm_led;

endmodule

// File: tb/tb_clock_controller.sv
module tb_clock_controller;

  localparam int unsigned CLK_FREQ     = 10;
  localparam int unsigned BLINK_CYCLES = 8;

  logic        clk;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_up;
  logic        alarm_en;
  logic [31:0] bcd;
  logic [7:0]  dots;
  logic        alarm_led;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        mode;
    logic        up;
    logic        aen;
    int unsigned cycles;
    logic [31:0] exp_bcd;
    logic [7:0]  exp_dots;
    logic        exp_led;
  } vec_t;

  vec_t run_tab[5];
  vec_t alarm_tab[12];

  clock_controller #(
    .CLK_FREQ     (CLK_FREQ),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .alarm_en   (alarm_en),
    .bcd        (bcd),
    .dots       (dots),
    .alarm_led  (alarm_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ups(input int n);
    repeat (n) begin
      btn_up = 1'b1;
      step();
      btn_up = 1'b0;
    end
  endtask

  task automatic mode_pulse();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] eb, input logic [7:0] ed,
                       input logic el);
    n_tests++;
    if (bcd !== eb || dots !== ed || alarm_led !== el) begin
      n_fail++;
      $display("FAIL %s: got bcd=%h dots=%b led=%b, expected bcd=%h dots=%b led=%b",
               name, bcd, dots, alarm_led, eb, ed, el);
    end
  endtask

  task automatic apply(input vec_t v);
    btn_mode = v.mode;
    btn_up   = v.up;
    alarm_en = v.aen;
    step();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    if (v.cycles > 1) idle(int'(v.cycles) - 1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    alarm_en = 1'b0;

    // Free-running count from reset, then entry into SET_HOUR clearing seconds.
    run_tab[0] = '{1'b0, 1'b0, 1'b0, 9,   32'hFF000000, 8'h14, 1'b0};
    run_tab[1] = '{1'b0, 1'b0, 1'b0, 1,   32'hFF000001, 8'h14, 1'b0};
    run_tab[2] = '{1'b0, 1'b0, 1'b0, 590, 32'hFF000100, 8'h14, 1'b0};
    run_tab[3] = '{1'b0, 1'b0, 1'b0, 35,  32'hFF000103, 8'h14, 1'b0};
    run_tab[4] = '{1'b1, 1'b0, 1'b0, 1,   32'hFF000100, 8'h14, 1'b0};

    // Alarm at 00:01 from 00:00:00, gating by alarm_en, then edit and reset mid-edit.
    alarm_tab[0]  = '{1'b0, 1'b0, 1'b1, 600, 32'hFF000100, 8'h14, 1'b0};
    alarm_tab[1]  = '{1'b0, 1'b0, 1'b1, 1,   32'hFF000100, 8'h14, 1'b1};
    alarm_tab[2]  = '{1'b0, 1'b0, 1'b0, 1,   32'hFF000100, 8'h14, 1'b0};
    alarm_tab[3]  = '{1'b0, 1'b0, 1'b1, 1,   32'hFF000100, 8'h14, 1'b1};
    alarm_tab[4]  = '{1'b0, 1'b0, 1'b1, 597, 32'hFF000200, 8'h14, 1'b1};
    alarm_tab[5]  = '{1'b0, 1'b0, 1'b1, 1,   32'hFF000200, 8'h14, 1'b0};
    alarm_tab[6]  = '{1'b1, 1'b0, 1'b1, 1,   32'hFF000200, 8'h14, 1'b0};
    alarm_tab[7]  = '{1'b1, 1'b0, 1'b1, 1,   32'hFF000200, 8'h14, 1'b0};
    alarm_tab[8]  = '{1'b1, 1'b0, 1'b1, 1,   32'hFF0001FF, 8'h94, 1'b0};
    alarm_tab[9]  = '{1'b1, 1'b0, 1'b1, 1,   32'hFF0001FF, 8'h94, 1'b0};
    alarm_tab[10] = '{1'b0, 1'b1, 1'b1, 1,   32'hFF0002FF, 8'h94, 1'b0};
    alarm_tab[11] = '{1'b0, 1'b0, 1'b1, 1,   32'hFF0002FF, 8'h94, 1'b1};

    #12;
    check("reset_state", 32'hFF000000, 8'h14, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply(run_tab[i]);
      check($sformatf("run_tab[%0d]", i), run_tab[i].exp_bcd, run_tab[i].exp_dots,
            run_tab[i].exp_led);
    end

    // SET_HOUR: 25 increments wrap to 01, hour byte blanked on phase 1.
    ups(25);
    check("hour_blink", 32'hFFFF0100, 8'h14, 1'b0);
    idle(7);
    check("hour_25_ups", 32'hFF010100, 8'h14, 1'b0);
    ups(22);
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    check("mode_wins", 32'hFF230100, 8'h14, 1'b0);

    // SET_MIN: wrap 59->00 without carry into hour.
    ups(1);
    check("min_inc", 32'hFF230200, 8'h14, 1'b0);
    ups(58);
    check("min_wrap_blank", 32'hFF23FF00, 8'h14, 1'b0);
    ups(59);
    check("min_59", 32'hFF235900, 8'h14, 1'b0);

    // Alarm 07:00 -> 00:01 while time keeps running.
    mode_pulse();
    check("ahour_view", 32'hFF0700FF, 8'h94, 1'b0);
    ups(17);
    check("ahour_wrap", 32'hFF0000FF, 8'h94, 1'b0);
    mode_pulse();
    check("amin_view", 32'hFF0000FF, 8'h94, 1'b0);
    ups(1);
    check("amin_inc", 32'hFF0001FF, 8'h94, 1'b0);
    mode_pulse();
    check("back_to_run", 32'hFF235902, 8'h14, 1'b0);

    // Full wrap 23:59:59 -> 00:00:00 on one tick.
    idle(569);
    check("pre_wrap", 32'hFF235959, 8'h14, 1'b0);
    idle(9);
    check("no_early_tick", 32'hFF235959, 8'h14, 1'b0);
    idle(1);
    check("full_wrap", 32'hFF000000, 8'h14, 1'b0);

    for (int i = 0; i < 12; i++) begin
      apply(alarm_tab[i]);
      check($sformatf("alarm_tab[%0d]", i), alarm_tab[i].exp_bcd, alarm_tab[i].exp_dots,
            alarm_tab[i].exp_led);
    end

    // Asynchronous reset between edges while editing in SET_AMIN.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'hFF000000, 8'h14, 1'b0);
    alarm_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode_pulse();
    mode_pulse();
    mode_pulse();
    check("alarm_reset_value", 32'hFF0700FF, 8'h94, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
